ps2_key_tracker: RTL and testbench

PS/2 keyboard front end. It deserialises raw PS/2 frames and tracks make/break (F0) sequences. It presents a held 8-bit scan code, which feeds the scan-code-to-ASCII lookup stage, plus a press counter for the seven-segment display. It is the stage directly upstream of the ASCII translation.

---
 rtl/ps2_key_tracker.sv | 159 +++++++++++++++
 tb/tb_ps2_key_tracker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: synchronises the raw pad signals, deserialises
// 11-bit frames, and tracks make/break sequences to present a held scan
// code, a key-held flag and a count of distinct new presses.
module ps2_key_tracker #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [7:0]       key_code,
    output logic             key_pressed,
    output logic [CNT_W-1:0] press_count,
    output logic             frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BREAK = 1'b1
    } state_t;

    // Synchronisers (idle bus is high)
    logic [2:0]       r_clk_sync;
    logic [1:0]       r_data_sync;

    // Frame receiver
    logic [3:0]       r_bit_cnt;
    logic [9:0]       r_shift;
    logic [TO_W-1:0]  r_to_cnt;
    logic [7:0]       r_byte;
    logic             r_byte_valid;
    logic             r_frame_err;

    // Tracker
    state_t           r_state;
    logic [7:0]       r_key_code;
    logic             r_key_pressed;
    logic [CNT_W-1:0] r_press_count;

    state_t           w_state_next;
    logic [7:0]       w_key_code_next;
    logic             w_key_pressed_next;
    logic [CNT_W-1:0] w_press_count_next;

    logic             w_fe;
    logic             w_sample;
    logic             w_frame_ok;

    // After ten shifts the buffer holds start in bit 0, data in 8:1 and
    // parity in bit 9; the stop bit is the live sample.
    assign w_fe       = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_sample   = r_data_sync[1];
    assign w_frame_ok = ~r_shift[0] & w_sample & (^r_shift[9:1]);

    // Bring the asynchronous pad signals into the clk domain
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    // Shift in frame bits on each falling edge, check the frame, and drop
    // a stalled partial frame after TIMEOUT_CYC quiet cycles
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_bit_cnt    <= 4'd0;
            r_shift      <= 10'd0;
            r_to_cnt     <= '0;
            r_byte       <= 8'd0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fe) begin
                r_to_cnt <= '0;
                if (r_bit_cnt < 4'd10) begin
                    r_shift   <= {w_sample, r_shift[9:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else begin
                    r_bit_cnt <= 4'd0;
                    if (w_frame_ok) begin
                        r_byte       <= r_shift[8:1];
                        r_byte_valid <= 1'b1;
                    end else begin
                        r_frame_err  <= 1'b1;
                    end
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    r_bit_cnt <= 4'd0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt  <= r_to_cnt + TO_W'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // Tracker state and registered outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state       <= S_IDLE;
            r_key_code    <= 8'd0;
            r_key_pressed <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_key_code    <= w_key_code_next;
            r_key_pressed <= w_key_pressed_next;
            r_press_count <= w_press_count_next;
        end
    end

    // Make/break decoding; the E0 extended prefix is transparent
    always_comb begin
        w_state_next       = r_state;
        w_key_code_next    = r_key_code;
        w_key_pressed_next = r_key_pressed;
        w_press_count_next = r_press_count;
        if (r_byte_valid && (r_byte != 8'hE0)) begin
            case (r_state)
                S_IDLE: begin
                    if (r_byte == 8'hF0) begin
                        w_state_next = S_BREAK;
                    end else if (!r_key_pressed || (r_byte != r_key_code)) begin
                        w_key_code_next    = r_byte;
                        w_key_pressed_next = 1'b1;
                        w_press_count_next = r_press_count + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (r_byte != 8'hF0) begin
                        if (r_byte == r_key_code) begin
                            w_key_pressed_next = 1'b0;
                        end
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign key_code    = r_key_code;
    assign key_pressed = r_key_pressed;
    assign press_count = r_press_count;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed PS/2 frames, with expected outputs
// queued by the stimulus and compared by an independent monitor.
module tb_ps2_key_tracker;

    localparam int CNT_W   = 8;
    localparam int TMO     = 4096;
    localparam int HALF    = 5;    // clk cycles per PS/2 clock half period

    logic             clk;
    logic             clrn;
    logic             ps2_clk;
    logic             ps2_data;
    logic [7:0]       key_code;
    logic             key_pressed;
    logic [CNT_W-1:0] press_count;
    logic             frame_err;

    ps2_key_tracker #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .press_count (press_count),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         due;
        logic [7:0] kc;
        logic       kp;
        logic [7:0] pc;
        int         errs;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   err_seen = 0;

    // Monitor: counts frame_err cycles and checks each expectation when due
    always @(negedge clk) begin
        exp_t e;
        if (frame_err === 1'b1) err_seen++;
        if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
            e = exp_q.pop_front();
            n_tests++;
            if (key_code !== e.kc || key_pressed !== e.kp ||
                press_count !== e.pc || err_seen != e.errs) begin
                n_fail++;
                $display("FAIL %s: got kc=%h kp=%b pc=%0d errs=%0d, want kc=%h kp=%b pc=%0d errs=%0d",
                         e.name, key_code, key_pressed, press_count, err_seen,
                         e.kc, e.kp, e.pc, e.errs);
            end else begin
                $display("ok   %s: kc=%h kp=%b pc=%0d errs=%0d",
                         e.name, key_code, key_pressed, press_count, err_seen);
            end
            err_seen = 0;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input int delay, input logic [7:0] kc,
                        input logic kp, input logic [7:0] pc, input int errs);
        exp_t e;
        e.name = name;
        e.due  = cyc + delay;
        e.kc   = kc;
        e.kp   = kp;
        e.pc   = pc;
        e.errs = errs;
        exp_q.push_back(e);
    endtask

    // {stop, parity, data, start}; odd parity unless flipped
    function automatic logic [10:0] mk(input logic [7:0] b, input logic pflip,
                                       input logic stp, input logic strt);
        return {stp, (~^b) ^ pflip, b, strt};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_clk(HALF);
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input string name, input logic [10:0] bits,
                              input logic [7:0] kc, input logic kp,
                              input logic [7:0] pc, input int errs);
        send_bits(bits, 11);
        push(name, 20, kc, kp, pc, errs);
        wait_clk(30);
    endtask

    task automatic do_reset(input string name);
        clrn = 1'b0;
        wait_clk(2);
        push(name, 1, 8'h00, 1'b0, 8'd0, 0);
        wait_clk(4);
        clrn = 1'b1;
        wait_clk(4);
    endtask

    initial begin
        logic [7:0] b;
        clrn     = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(3);
        do_reset("reset");

        // Make, break, re-make
        send_frame("make_1C",      mk(8'h1C, 0, 1, 0), 8'h1C, 1, 8'd1, 0);
        send_frame("brk_F0",       mk(8'hF0, 0, 1, 0), 8'h1C, 1, 8'd1, 0);
        send_frame("brk_1C",       mk(8'h1C, 0, 1, 0), 8'h1C, 0, 8'd1, 0);
        // New press of same code after release, then typematic repeats
        send_frame("remake_1C",    mk(8'h1C, 0, 1, 0), 8'h1C, 1, 8'd2, 0);
        send_frame("rep_1C_a",     mk(8'h1C, 0, 1, 0), 8'h1C, 1, 8'd2, 0);
        send_frame("rep_1C_b",     mk(8'h1C, 0, 1, 0), 8'h1C, 1, 8'd2, 0);
        send_frame("make_32",      mk(8'h32, 0, 1, 0), 8'h32, 1, 8'd3, 0);
        // E0 ignored in both states; untracked release
        send_frame("ext_E0",       mk(8'hE0, 0, 1, 0), 8'h32, 1, 8'd3, 0);
        send_frame("brk_F0_b",     mk(8'hF0, 0, 1, 0), 8'h32, 1, 8'd3, 0);
        send_frame("ext_E0_brk",   mk(8'hE0, 0, 1, 0), 8'h32, 1, 8'd3, 0);
        send_frame("rel_untrk_1C", mk(8'h1C, 0, 1, 0), 8'h32, 1, 8'd3, 0);
        send_frame("make_1C_b",    mk(8'h1C, 0, 1, 0), 8'h1C, 1, 8'd4, 0);
        // Rejected frames
        send_frame("bad_parity",   mk(8'h32, 1, 1, 0), 8'h1C, 1, 8'd4, 1);
        send_frame("bad_stop",     mk(8'h32, 0, 0, 0), 8'h1C, 1, 8'd4, 1);
        send_frame("bad_start",    mk(8'h32, 0, 1, 1), 8'h1C, 1, 8'd4, 1);
        // Repeated F0 stays in break
        send_frame("brk_F0_c",     mk(8'hF0, 0, 1, 0), 8'h1C, 1, 8'd4, 0);
        send_frame("brk_F0_d",     mk(8'hF0, 0, 1, 0), 8'h1C, 1, 8'd4, 0);
        send_frame("brk_1C_b",     mk(8'h1C, 0, 1, 0), 8'h1C, 0, 8'd4, 0);

        // Stalled partial frame is abandoned silently
        send_bits(mk(8'hAA, 0, 1, 0), 5);
        wait_clk(TMO + 10);
        send_frame("after_timeout", mk(8'h1B, 0, 1, 0), 8'h1B, 1, 8'd5, 0);

        // Reset mid-frame
        send_bits(mk(8'h3C, 0, 1, 0), 6);
        do_reset("reset_midframe");
        send_frame("post_rst_15",  mk(8'h15, 0, 1, 0), 8'h15, 1, 8'd1, 0);

        // Press counter wrap over 256 distinct makes
        do_reset("reset_wrap");
        for (int i = 0; i < 256; i++) begin
            b = (i % 2 == 0) ? 8'h1C : 8'h32;
            send_frame($sformatf("wrap_%0d", i), mk(b, 0, 1, 0), b, 1,
                       8'((i + 1) % 256), 0);
        end

        for (int k = 0; k < 200 && exp_q.size() > 0; k++) wait_clk(1);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
